// File: rtl/xm_pkg.sv
// xm_pkg: shared XM register offsets, control-bit indices and FSM states
package xm_pkg;
   localparam logic [3:0] XM_CTRL1_OFS = 4'h0;
   localparam logic [3:0] XM_CTRL4_OFS = 4'h1;
   localparam logic [3:0] XM_CTRL5_OFS = 4'h2;
   localparam logic [3:0] XM_CTRL2_OFS = 4'h8;
   localparam logic [3:0] XM_CTRL3_OFS = 4'hC;
   localparam int POKEY_EN   = 4;
   localparam int HSC_EN     = 3;
   localparam int YM_EN      = 7;
   localparam int BANK0_EN   = 5;
   localparam int BANK1_EN   = 6;
   localparam int WE_DIS     = 1;
   localparam int LOCK_POKEY = 3;
   localparam int LOCK_HSC   = 4;
   localparam int LOCK_TOP   = 7;
   typedef enum logic [1:0] {IDLE = 2'd0, RD_WAIT = 2'd1, WR_WAIT = 2'd2} xm_state_t;
endpackage

// File: rtl/xm_ram_port.sv
// xm_ram_port: req/ack external RAM sequencer with read latch and late-strobe counter
module xm_ram_port
   import xm_pkg::*;
#(
   parameter int RAM_ADDR_W = 17,
   parameter int LATE_W     = 8
) (
   input  logic                  clk_sys,
   input  logic                  reset,
   input  logic                  launch_rd,
   input  logic                  launch_wr,
   input  logic [RAM_ADDR_W-1:0] addr,
   input  logic [7:0]            wdata,
   input  logic                  strobe,
   input  logic                  ram_ack,
   input  logic [7:0]            ram_rdata,
   output logic                  ram_req,
   output logic                  ram_we,
   output logic [RAM_ADDR_W-1:0] ram_addr,
   output logic [7:0]            ram_wdata,
   output logic [7:0]            rd_latch,
   output logic [LATE_W-1:0]     late_cnt
);
   xm_state_t state_q, state_d;
   logic req_q, req_d, we_q, we_d;
   logic [RAM_ADDR_W-1:0] addr_q, addr_d;
   logic [7:0] wdata_q, wdata_d, rd_q, rd_d;
   logic [LATE_W-1:0] late_q, late_d;
   // Launch from IDLE (write wins), otherwise hold the request, count late strobes and retire on ack
   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rd_d    = rd_q;
      late_d  = late_q;
      if (state_q == IDLE) begin
         if (launch_wr) begin
            state_d = WR_WAIT;
            req_d   = 1'b1;
            we_d    = 1'b1;
            addr_d  = addr;
            wdata_d = wdata;
         end else if (launch_rd) begin
            state_d = RD_WAIT;
            req_d   = 1'b1;
            we_d    = 1'b0;
            addr_d  = addr;
         end
      end else begin
         if (strobe && late_q != '1) late_d = late_q + LATE_W'(1);
         if (ram_ack) begin
            state_d = IDLE;
            req_d   = 1'b0;
            we_d    = 1'b0;
            if (state_q == RD_WAIT) rd_d = ram_rdata;
         end
      end
   end
   // State register; reset abandons any pending access
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_q <= IDLE;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rd_q    <= '0;
         late_q  <= '0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rd_q    <= rd_d;
         late_q  <= late_d;
      end
   end
   assign ram_req   = req_q;
   assign ram_we    = we_q;
   assign ram_addr  = addr_q;
   assign ram_wdata = wdata_q;
   assign rd_latch  = rd_q;
   assign late_cnt  = late_q;
endmodule

// File: rtl/xm_expansion_ctrl.sv
// xm_expansion_ctrl: XM control registers with locks plus paged RAM windows on an external port
module xm_expansion_ctrl
   import xm_pkg::*;
#(
   parameter int PAGE_W     = 4,
   parameter int RAM_ADDR_W = 17,
   parameter int LATE_W     = 8
) (
   input  logic                  clk_sys,
   input  logic                  reset,
   input  logic                  pclk0,
   input  logic                  pclk1,
   input  logic                  xm_en,
   input  logic                  cart_cs,
   input  logic [15:0]           address_in,
   input  logic [7:0]            din,
   input  logic                  rw,
   input  logic                  halt_n,
   output logic [7:0]            dout,
   output logic                  dout_en,
   output logic                  ram_req,
   output logic                  ram_we,
   output logic [RAM_ADDR_W-1:0] ram_addr,
   output logic [7:0]            ram_wdata,
   input  logic                  ram_ack,
   input  logic [7:0]            ram_rdata,
   output logic                  pokey_en,
   output logic                  ym_en,
   output logic                  hsc_en,
   output logic [LATE_W-1:0]     late_cnt
);
   logic [7:0] x1_q, x1_d, x2_q, x2_d, x3_q, x3_d, x4_q, x4_d, x5_q, x5_d;
   logic [3:0] ofs, nib;
   logic [7:0] pg_src, reg_val, rd_latch;
   logic blk, reg_sel, dec, wr, win0, win1, win;
   logic [RAM_ADDR_W-1:0] addr;
   assign ofs     = address_in[3:0];
   assign blk     = xm_en && cart_cs;
   assign reg_sel = blk && address_in[15:4] == 12'h047;
   assign dec     = reg_sel && (ofs inside {XM_CTRL1_OFS, XM_CTRL4_OFS, XM_CTRL5_OFS, XM_CTRL2_OFS, XM_CTRL3_OFS});
   assign wr      = pclk0 && !rw;
   assign win0    = blk && !reg_sel && address_in[15:13] == 3'b010 && x1_q[BANK0_EN];
   assign win1    = blk && !reg_sel && address_in[15:13] == 3'b011 && x1_q[BANK1_EN];
   assign win     = win0 || win1;
   assign pg_src  = halt_n ? x2_q : x3_q;
   assign nib     = win1 ? pg_src[7:4] : pg_src[3:0];
   assign addr    = RAM_ADDR_W'({nib[PAGE_W-1:0], address_in[12:0]});
   assign reg_val = ofs == XM_CTRL1_OFS ? x1_q :
                    ofs == XM_CTRL4_OFS ? x4_q :
                    ofs == XM_CTRL5_OFS ? x5_q :
                    ofs == XM_CTRL2_OFS ? x2_q : x3_q;
   assign dout_en = rw && (dec || win);
   assign dout    = !rw ? 8'h00 : dec ? reg_val : win ? rd_latch : 8'h00;
   assign pokey_en = x1_q[POKEY_EN];
   assign ym_en    = x1_q[YM_EN];
   assign hsc_en   = x1_q[HSC_EN];
   // Register writes; locks look at the XCTRL5 value from before this write
   always_comb begin
      x1_d = x1_q;
      x2_d = x2_q;
      x3_d = x3_q;
      x4_d = x4_q;
      x5_d = x5_q;
      if (dec && wr) begin
         if (ofs == XM_CTRL1_OFS) begin
            x1_d = din;
            x1_d[POKEY_EN] = x5_q[LOCK_POKEY] ? x1_q[POKEY_EN] : din[POKEY_EN];
            x1_d[HSC_EN]   = din[HSC_EN] | (x5_q[LOCK_HSC] & x1_q[HSC_EN]);
         end
         if (ofs == XM_CTRL4_OFS) x4_d = x4_q[LOCK_TOP] ? x4_q : din;
         if (ofs == XM_CTRL5_OFS) x5_d = din | (x5_q & 8'h38);
         if (ofs == XM_CTRL2_OFS) x2_d = din;
         if (ofs == XM_CTRL3_OFS) x3_d = din;
      end
   end
   // Control register bank
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         x1_q <= '0;
         x2_q <= '0;
         x3_q <= '0;
         x4_q <= '0;
         x5_q <= '0;
      end else begin
         x1_q <= x1_d;
         x2_q <= x2_d;
         x3_q <= x3_d;
         x4_q <= x4_d;
         x5_q <= x5_d;
      end
   end
   xm_ram_port #(.RAM_ADDR_W(RAM_ADDR_W), .LATE_W(LATE_W)) u_port (
      .clk_sys   (clk_sys),
      .reset     (reset),
      .launch_rd (pclk1 && !pclk0 && win && rw),
      .launch_wr (pclk0 && win && !rw && !x5_q[WE_DIS]),
      .addr      (addr),
      .wdata     (din),
      .strobe    (pclk0 || pclk1),
      .ram_ack   (ram_ack),
      .ram_rdata (ram_rdata),
      .ram_req   (ram_req),
      .ram_we    (ram_we),
      .ram_addr  (ram_addr),
      .ram_wdata (ram_wdata),
      .rd_latch  (rd_latch),
      .late_cnt  (late_cnt)
   );
endmodule
